sdram_cmd_arb: RTL and testbench
================================

SDRAM_CMD_ARB -- requirements
Module: sdram_cmd_arb

Interface
- REQ-001: Parameter N_CH, default 4: number of requesting controllers; channel 0 is the init/refresh owner.
- REQ-002: Parameter ADDR_W, default 13: DRAM_ADDR width.
- REQ-003: Parameter BA_W, default 2: DRAM_BA width.
- REQ-004: Parameter DQ_W, default 16: DRAM_DQ width.
- REQ-005: Parameter GAP_CYC, default 1, range 1..7: NOP turnaround cycles after each release.
- REQ-006: Clock and reset: one clock; reset is synchronous and active-high.
- REQ-007: clk  in  1  sole clock; all state changes on its rising edge.
- REQ-008: rst  in  1  synchronous active-high reset.
- REQ-009: req  in  N_CH  per-channel bus request, level.
- REQ-010: rel  in  N_CH  per-channel release pulse; honoured only from the owner.
- REQ-011: gnt  out  N_CH  one-hot or zero ownership indication, registered.
- REQ-012: ch_cmd  in  4*N_CH  per-channel {CS_N,RAS_N,CAS_N,WE_N}.
- REQ-013: ch_addr  in  ADDR_W*N_CH; ch_ba  in  BA_W*N_CH; ch_dqm  in  2*N_CH {UDQM,LDQM}.
- REQ-014: ch_dq_o  in  DQ_W*N_CH write data; ch_dq_oe  in  N_CH write-data enable.
- REQ-015: dq_i  out  DQ_W  DRAM_DQ sampled every cycle, broadcast to all channels.
- REQ-016: DRAM_ADDR, DRAM_BA, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N, DRAM_CKE, DRAM_LDQM, DRAM_UDQM  out, registered; DRAM_DQ  inout  DQ_W.

Function
- REQ-017: States IDLE, OWN, GAP; reset state IDLE.
- REQ-018: IDLE with any req: winner is registered into gnt on the next edge and state becomes OWN; no req keeps IDLE.
- REQ-019: Channel 0 req always wins arbitration in IDLE; channel 0 never preempts a current owner.
- REQ-020: OWN: owner's cmd/addr/ba/dqm appear on DRAM pins one cycle after sampling (latency 1); DRAM_DQ driven with owner's ch_dq_o, registered, only when owner's ch_dq_oe was high, else high-Z.
- REQ-021: OWN ends when owner's rel is high: gnt clears next edge, state GAP; owner's req level is ignored for release.
- REQ-022: rel from non-owners, or in IDLE/GAP, is ignored.
- REQ-023: GAP: pins carry NOP (CS_N=0, RAS_N=CAS_N=WE_N=1), DQ high-Z, DQM high, for exactly GAP_CYC cycles, then IDLE.
- REQ-024: IDLE and GAP drive NOP on the command pins; non-owner inputs never reach the pins.
- REQ-025: Requests arriving during OWN/GAP are held by the requester and arbitrated at the next IDLE; no request is queued internally.
- REQ-026: Minimum ownership 1 cycle: rel in the first OWN cycle is honoured.

Reset
- REQ-027: On rst: gnt=0, state IDLE, gap counter 0, round-robin pointer to channel 1.
- REQ-028: On rst: DRAM_CS_N=1, RAS_N=CAS_N=WE_N=1, ADDR=0, BA=0, DQM=2'b11, DQ high-Z, DRAM_CKE=0; CKE goes 1 on the first cycle after rst deasserts and stays 1.
- REQ-029: rst mid-OWN drops ownership immediately with no GAP.

Configuration
- REQ-030: Macro SDRAM_ARB_RR_EN defined: channels 1..N_CH-1 arbitrated round-robin; pointer moves to owner+1 (wrapping N_CH-1 to 1) on each grant to a non-zero channel.
- REQ-031: SDRAM_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register.

Structure
- REQ-032: Package sdram_pkg holds the 4-bit command typedef, CMD_NOP and CMD_DESL constants, and the state enum.
- REQ-033: Winner selection lives in sub-module sdram_arb_pick (req vector, pointer in; one-hot winner out), combinational.

Verification
- REQ-034: rst for 3 cycles -> CS_N=1, DQM=11, CKE=0, gnt=0; cycle after release CKE=1.
- REQ-035: req=4'b0110 from IDLE, RR_EN defined -> gnt=0010; owner rel -> gnt=0 for GAP_CYC cycles then gnt=0100.
- REQ-036: channel 2 owns, channel 0 raises req -> no preemption; after rel and GAP, gnt=0001 despite req[3]=1.
- REQ-037: owner ch1 drives ch_cmd=ACTIVE, addr=13'h0155, ba=2, dq_oe=1, dq=16'hA5A5 -> pins show them next cycle; ch3 values never appear.
- REQ-038: rel from non-owner ch3 while ch1 owns -> ignored, ch1 keeps gnt; rst asserted mid-OWN -> gnt=0 and DESL next edge.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM command arbiter: the pin command encoding, the FSM states
// and the round-robin slot helper.
package sdram_pkg;

   // Command bit order is {CS_N, RAS_N, CAS_N, WE_N}.
   typedef logic [3:0] sdram_cmd_t;

   localparam sdram_cmd_t CMD_NOP  = 4'b0111;
   localparam sdram_cmd_t CMD_DESL = 4'b1111;

   typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_t;

   // k-th candidate after ptr among channels 1..n_ch-1, wrapping back to 1.
   function automatic int rr_slot(input int ptr, input int k, input int n_ch);
      int slot;
      slot = ptr + k;
      if (slot >= n_ch) slot = slot - (n_ch - 1);
      return slot;
   endfunction

endpackage

// File: rtl/sdram_cmd_arb_if.sv
// Per-channel request/grant and command bus between the SDRAM controllers and the arbiter.
// The controllers use the master modport and the arbiter uses the slave modport.
interface sdram_cmd_arb_if #(
   parameter int N_CH   = 4,
   parameter int ADDR_W = 13,
   parameter int BA_W   = 2,
   parameter int DQ_W   = 16
);
   logic [N_CH-1:0]        req;
   logic [N_CH-1:0]        rel;
   logic [N_CH-1:0]        gnt;
   logic [4*N_CH-1:0]      ch_cmd;
   logic [ADDR_W*N_CH-1:0] ch_addr;
   logic [BA_W*N_CH-1:0]   ch_ba;
   logic [2*N_CH-1:0]      ch_dqm;
   logic [DQ_W*N_CH-1:0]   ch_dq_o;
   logic [N_CH-1:0]        ch_dq_oe;
   logic [DQ_W-1:0]        dq_i;

   modport master (
      output req, rel, ch_cmd, ch_addr, ch_ba, ch_dqm, ch_dq_o, ch_dq_oe,
      input  gnt, dq_i
   );

   modport slave (
      input  req, rel, ch_cmd, ch_addr, ch_ba, ch_dqm, ch_dq_o, ch_dq_oe,
      output gnt, dq_i
   );
endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational winner select: channel 0 always wins. With SDRAM_ARB_RR_EN, channels
// 1..N_CH-1 rotate from i_ptr; otherwise the lowest index wins. No latency, no backpressure.
module sdram_arb_pick
   import sdram_pkg::*;
#(
   parameter int N_CH = 4
) (
   input  logic [N_CH-1:0]         i_req,
`ifdef SDRAM_ARB_RR_EN
   input  logic [$clog2(N_CH)-1:0] i_ptr,
`endif
   output logic [N_CH-1:0]         o_win
);

`ifdef SDRAM_ARB_RR_EN
   logic w_found;

   always_comb begin
      o_win   = '0;
      w_found = 1'b0;
      if (i_req[0]) begin
         o_win[0] = 1'b1;
         w_found  = 1'b1;
      end
      for (int k = 0; k < N_CH - 1; k++) begin
         for (int ch = 1; ch < N_CH; ch++) begin
            if (!w_found && i_req[ch] && ch == rr_slot(int'(i_ptr), k, N_CH)) begin
               o_win[ch] = 1'b1;
               w_found   = 1'b1;
            end
         end
      end
   end
`else
   // Isolate the lowest set bit; channel 0 wins by being lowest.
   assign o_win = i_req & (~i_req + N_CH'(1));
`endif

endmodule

// File: rtl/sdram_cmd_arb.sv
// Shares one SDRAM pin set among N_CH controllers. The owner's command reaches the pins with 1-cycle latency.
// Release is followed by GAP_CYC NOP cycles. Losers hold req. SDRAM_ARB_RR_EN selects round-robin for channels 1..N_CH-1.
module sdram_cmd_arb
   import sdram_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int ADDR_W  = 13,
   parameter int BA_W    = 2,
   parameter int DQ_W    = 16,
   parameter int GAP_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   sdram_cmd_arb_if.slave    bus,
   output logic [ADDR_W-1:0] DRAM_ADDR,
   output logic [BA_W-1:0]   DRAM_BA,
   output logic              DRAM_CS_N,
   output logic              DRAM_RAS_N,
   output logic              DRAM_CAS_N,
   output logic              DRAM_WE_N,
   output logic              DRAM_CKE,
   output logic              DRAM_LDQM,
   output logic              DRAM_UDQM,
   inout  wire  [DQ_W-1:0]   DRAM_DQ
);

   arb_state_t        r_state, w_state_nxt;
   logic [N_CH-1:0]   r_gnt, w_gnt_nxt, w_win;
   logic [2:0]        r_gap_cnt, w_gap_nxt;
`ifdef SDRAM_ARB_RR_EN
   localparam int PTR_W = $clog2(N_CH);
   logic [PTR_W-1:0]  r_ptr, w_ptr_nxt;
`endif

   sdram_cmd_t        r_cmd, w_own_cmd;
   logic [ADDR_W-1:0] r_addr, w_own_addr;
   logic [BA_W-1:0]   r_ba, w_own_ba;
   logic [1:0]        r_dqm, w_own_dqm;
   logic [DQ_W-1:0]   r_dq_o, w_own_dq;
   logic              r_dq_oe, w_own_oe;
   logic              r_cke;
   logic [DQ_W-1:0]   r_dq_i;

   sdram_arb_pick #(.N_CH(N_CH)) u_pick (
      .i_req (bus.req),
`ifdef SDRAM_ARB_RR_EN
      .i_ptr (r_ptr),
`endif
      .o_win (w_win)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_gap_cnt <= '0;
`ifdef SDRAM_ARB_RR_EN
         r_ptr     <= PTR_W'(1);
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_gap_cnt <= w_gap_nxt;
`ifdef SDRAM_ARB_RR_EN
         r_ptr     <= w_ptr_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_gap_nxt   = r_gap_cnt;
`ifdef SDRAM_ARB_RR_EN
      w_ptr_nxt   = r_ptr;
`endif
      case (r_state)
         IDLE: begin
            if (|bus.req) begin
               w_gnt_nxt   = w_win;
               w_state_nxt = OWN;
`ifdef SDRAM_ARB_RR_EN
               for (int ch = 1; ch < N_CH; ch++)
                  if (w_win[ch]) w_ptr_nxt = (ch == N_CH - 1) ? PTR_W'(1) : PTR_W'(ch + 1);
`endif
            end
         end
         OWN: begin
            // Only the owner's rel counts; its req level is irrelevant here.
            if (|(bus.rel & r_gnt)) begin
               w_gnt_nxt   = '0;
               w_gap_nxt   = '0;
               w_state_nxt = GAP;
            end
         end
         GAP: begin
            if (r_gap_cnt == 3'(GAP_CYC - 1)) begin
               w_gap_nxt   = '0;
               w_state_nxt = IDLE;
            end else begin
               w_gap_nxt   = r_gap_cnt + 3'd1;
            end
         end
         default: begin
            w_gnt_nxt   = '0;
            w_gap_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      w_own_cmd  = CMD_NOP;
      w_own_addr = '0;
      w_own_ba   = '0;
      w_own_dqm  = 2'b11;
      w_own_dq   = '0;
      w_own_oe   = 1'b0;
      for (int ch = 0; ch < N_CH; ch++) begin
         if (r_gnt[ch]) begin
            w_own_cmd  = bus.ch_cmd[4*ch +: 4];
            w_own_addr = bus.ch_addr[ADDR_W*ch +: ADDR_W];
            w_own_ba   = bus.ch_ba[BA_W*ch +: BA_W];
            w_own_dqm  = bus.ch_dqm[2*ch +: 2];
            w_own_dq   = bus.ch_dq_o[DQ_W*ch +: DQ_W];
            w_own_oe   = bus.ch_dq_oe[ch];
         end
      end
   end

   // Pins follow the owner only while in OWN; IDLE/GAP force NOP with DQM high.
   always_ff @(posedge clk) begin
      r_dq_i <= DRAM_DQ;
      if (rst) begin
         r_cmd   <= CMD_DESL;
         r_addr  <= '0;
         r_ba    <= '0;
         r_dqm   <= 2'b11;
         r_dq_o  <= '0;
         r_dq_oe <= 1'b0;
         r_cke   <= 1'b0;
      end else begin
         r_cke <= 1'b1;
         if (r_state == OWN) begin
            r_cmd   <= w_own_cmd;
            r_addr  <= w_own_addr;
            r_ba    <= w_own_ba;
            r_dqm   <= w_own_dqm;
            r_dq_o  <= w_own_dq;
            r_dq_oe <= w_own_oe;
         end else begin
            r_cmd   <= CMD_NOP;
            r_addr  <= '0;
            r_ba    <= '0;
            r_dqm   <= 2'b11;
            r_dq_o  <= '0;
            r_dq_oe <= 1'b0;
         end
      end
   end

   assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = r_cmd;
   assign DRAM_ADDR = r_addr;
   assign DRAM_BA   = r_ba;
   assign DRAM_UDQM = r_dqm[1];
   assign DRAM_LDQM = r_dqm[0];
   assign DRAM_CKE  = r_cke;
   assign DRAM_DQ   = r_dq_oe ? r_dq_o : {DQ_W{1'bz}};
   assign bus.gnt   = r_gnt;
   assign bus.dq_i  = r_dq_i;

endmodule

// File: tb/tb_sdram_cmd_arb.sv
// Directed-vector bench for sdram_cmd_arb with GAP_CYC=2. Expected pin/grant state is
// queued at stimulus time and popped by an independent monitor after each clock edge.
module tb_sdram_cmd_arb;
   import sdram_pkg::*;

   localparam int NOPS = 4;
   localparam int RSTS = 5;
`ifdef SDRAM_ARB_RR_EN
   localparam int SEC = 2;
`else
   localparam int SEC = 1;
`endif
   localparam logic [3:0] SEC_G = 4'b0001 << SEC;

   typedef struct {
      logic [3:0]  gnt;
      int          src;
      logic        cke;
      logic        chk_dqi;
      logic [15:0] dqi;
   } exp_t;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] rel;
      exp_t       e;
   } row_t;

   logic clk;
   logic rst;
   logic [12:0] dram_addr;
   logic [1:0]  dram_ba;
   logic cs_n, ras_n, cas_n, we_n, cke, ldqm, udqm;
   wire  [15:0] dram_dq;

   logic [3:0]  c_cmd  [4] = '{4'b0001, 4'b0011, 4'b0101, 4'b0100};
   logic [12:0] c_addr [4] = '{13'h0400, 13'h0155, 13'h0022, 13'h1AAA};
   logic [1:0]  c_ba   [4] = '{2'd0, 2'd2, 2'd3, 2'd1};
   logic [1:0]  c_dqm  [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
   logic [15:0] c_dq   [4] = '{16'h0000, 16'hA5A5, 16'h1234, 16'h5A5A};
   logic        c_oe   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   row_t rows[$];
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   mon_row = 0;

   sdram_cmd_arb_if #(.N_CH(4), .ADDR_W(13), .BA_W(2), .DQ_W(16)) bus ();

   sdram_cmd_arb #(.N_CH(4), .ADDR_W(13), .BA_W(2), .DQ_W(16), .GAP_CYC(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .DRAM_ADDR  (dram_addr),
      .DRAM_BA    (dram_ba),
      .DRAM_CS_N  (cs_n),
      .DRAM_RAS_N (ras_n),
      .DRAM_CAS_N (cas_n),
      .DRAM_WE_N  (we_n),
      .DRAM_CKE   (cke),
      .DRAM_LDQM  (ldqm),
      .DRAM_UDQM  (udqm),
      .DRAM_DQ    (dram_dq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got %h, expected %h", name, mon_row, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] rl,
                      input logic [3:0] g, input int src, input logic ck,
                      input logic cd, input logic [15:0] dqi);
      row_t x;
      x.rst = r; x.req = rq; x.rel = rl;
      x.e.gnt = g; x.e.src = src; x.e.cke = ck; x.e.chk_dqi = cd; x.e.dqi = dqi;
      rows.push_back(x);
   endtask

   // Monitor: one expectation per clock, sampled 1 time unit after the edge.
   always @(posedge clk) begin
      exp_t e;
      logic [3:0] ecmd;
      logic [1:0] edqm;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         ecmd = (e.src < 4) ? c_cmd[e.src] : ((e.src == RSTS) ? 4'b1111 : 4'b0111);
         edqm = (e.src < 4) ? c_dqm[e.src] : 2'b11;
         chk("gnt", 32'(bus.gnt), 32'(e.gnt));
         chk("cke", 32'(cke), 32'(e.cke));
         chk("cmd", 32'({cs_n, ras_n, cas_n, we_n}), 32'(ecmd));
         chk("dqm", 32'({udqm, ldqm}), 32'(edqm));
         if (e.src == RSTS) begin
            chk("rst_addr", 32'(dram_addr), 32'd0);
            chk("rst_ba", 32'(dram_ba), 32'd0);
         end else if (e.src < 4) begin
            chk("addr", 32'(dram_addr), 32'(c_addr[e.src]));
            chk("ba", 32'(dram_ba), 32'(c_ba[e.src]));
            if (c_oe[e.src]) chk("dq", 32'(dram_dq), 32'(c_dq[e.src]));
         end
         if (e.chk_dqi) chk("dq_i", 32'(bus.dq_i), 32'(e.dqi));
         mon_row++;
      end
   end

   initial begin
      rst = 1'b1;
      bus.req = '0;
      bus.rel = '0;
      for (int i = 0; i < 4; i++) begin
         bus.ch_cmd[4*i +: 4]    = c_cmd[i];
         bus.ch_addr[13*i +: 13] = c_addr[i];
         bus.ch_ba[2*i +: 2]     = c_ba[i];
         bus.ch_dqm[2*i +: 2]    = c_dqm[i];
         bus.ch_dq_o[16*i +: 16] = c_dq[i];
         bus.ch_dq_oe[i]         = c_oe[i];
      end

      //  rst  req      rel      gnt      src   cke chk dq_i
      add(1, 4'b0000, 4'b0000, 4'b0000, RSTS, 0, 0, 16'h0);
      add(1, 4'b0000, 4'b0000, 4'b0000, RSTS, 0, 0, 16'h0);
      add(1, 4'b0000, 4'b0000, 4'b0000, RSTS, 0, 0, 16'h0);
      add(0, 4'b0000, 4'b0000, 4'b0000, NOPS, 1, 0, 16'h0);
      add(0, 4'b0110, 4'b0000, 4'b0010, NOPS, 1, 0, 16'h0);
      add(0, 4'b0110, 4'b1000, 4'b0010, 1,    1, 0, 16'h0);    // non-owner rel ignored
      add(0, 4'b0110, 4'b0010, 4'b0000, 1,    1, 1, 16'hA5A5);
      add(0, 4'b0110, 4'b0000, 4'b0000, NOPS, 1, 1, 16'hA5A5);
      add(0, 4'b0110, 4'b0000, 4'b0000, NOPS, 1, 0, 16'h0);
      add(0, 4'b0110, 4'b0000, SEC_G,   NOPS, 1, 0, 16'h0);
      add(0, 4'b0110, 4'b0000, SEC_G,   SEC,  1, 0, 16'h0);
      add(0, 4'b0111, 4'b0000, SEC_G,   SEC,  1, 0, 16'h0);    // ch0 cannot preempt
      add(0, 4'b1111, SEC_G,   4'b0000, SEC,  1, 0, 16'h0);
      add(0, 4'b1111, 4'b0000, 4'b0000, NOPS, 1, 0, 16'h0);
      add(0, 4'b1111, 4'b0000, 4'b0000, NOPS, 1, 0, 16'h0);
      add(0, 4'b1111, 4'b0000, 4'b0001, NOPS, 1, 0, 16'h0);    // ch0 wins over ch3
      add(0, 4'b1110, 4'b0001, 4'b0000, 0,    1, 0, 16'h0);    // rel in first OWN cycle
      add(0, 4'b1000, 4'b0000, 4'b0000, NOPS, 1, 0, 16'h0);
      add(0, 4'b1000, 4'b0000, 4'b0000, NOPS, 1, 0, 16'h0);
      add(0, 4'b1000, 4'b0000, 4'b1000, NOPS, 1, 0, 16'h0);
      add(0, 4'b1000, 4'b0000, 4'b1000, 3,    1, 0, 16'h0);
      add(1, 4'b1000, 4'b0000, 4'b0000, RSTS, 0, 0, 16'h0);    // rst mid-OWN
      add(0, 4'b0000, 4'b0000, 4'b0000, NOPS, 1, 0, 16'h0);

      foreach (rows[i]) begin
         @(negedge clk);
         rst     = rows[i].rst;
         bus.req = rows[i].req;
         bus.rel = rows[i].rel;
         exp_q.push_back(rows[i].e);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
